// File: rtl/baser_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : baser_pkg
//  Brief    : Shared constants, block type and helpers for the 10GBASE-R
//             transmit scrambler / gearbox slice.
//  Revision : 1.0  initial release
// ============================================================================
package baser_pkg;

    localparam logic [1:0] SYNC_DATA   = 2'b01;
    localparam logic [1:0] SYNC_CTRL   = 2'b10;

    localparam int SCR_TAP_A   = 38;
    localparam int SCR_TAP_B   = 57;
    localparam int SCR_WIDTH   = 58;
    localparam int GBX_SEQ_MAX = 32;

    typedef struct packed {
        logic [1:0]  hdr;
        logic [63:0] data;
    } block66_t;

    // Mirror a 64-bit word so bit 0 becomes bit 63.
    function automatic logic [63:0] bit_reverse64(input logic [63:0] v);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            r[i] = v[63-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_scrambler_64.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_scrambler_64
//  Brief    : Combinational 64-bit unrolled step of the x^58+x^39+1
//             self-synchronising scrambler. The caller owns the state flop.
//  Revision : 1.0  initial release
// ============================================================================
module lfsr_scrambler_64
    import baser_pkg::*;
(
    input  logic [SCR_WIDTH-1:0] state_in,
    input  logic [63:0]          data_in,
    output logic [63:0]          data_out,
    output logic [SCR_WIDTH-1:0] state_out
);

    // Apply the serial recurrence once per payload bit, LSB first.
    always_comb begin
        logic [SCR_WIDTH-1:0] s;
        s        = state_in;
        data_out = '0;
        for (int i = 0; i < 64; i++) begin
            data_out[i] = data_in[i] ^ s[SCR_TAP_A] ^ s[SCR_TAP_B];
            s           = {s[SCR_WIDTH-2:0], data_out[i]};
        end
        state_out = s;
    end

endmodule
`default_nettype wire

// File: rtl/baser_tx_scrambler_gearbox.sv
`default_nettype none
// ============================================================================
//  Module   : baser_tx_scrambler_gearbox
//  Brief    : Scrambles 66-bit 10GBASE-R blocks and repacks them into a
//             continuous 64-bit SERDES word stream (32 blocks per 33 clks).
//  Revision : 1.0  initial release
// ============================================================================
module baser_tx_scrambler_gearbox
    import baser_pkg::*;
#(
    parameter int DATA_WIDTH        = 64,
    parameter int HDR_WIDTH         = 2,
    parameter int SCRAMBLER_DISABLE = 0,
    parameter int BIT_REVERSE       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] encoded_tx_data,
    input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
    output logic                  tx_pause,
    output logic [DATA_WIDTH-1:0] serdes_tx_data
);

    block66_t             blk;
    logic [63:0]          scr_data;
    logic [SCR_WIDTH-1:0] lfsr_step;

    logic [5:0]           seq_cnt_q,  seq_cnt_d;
    logic [63:0]          leftover_q, leftover_d;
    logic [63:0]          serdes_q,   serdes_d;
    logic [SCR_WIDTH-1:0] lfsr_q,     lfsr_d;

    logic                 pause;
    logic [127:0]         cat;
    logic [63:0]          word;

    assign blk.hdr  = encoded_tx_hdr;
    assign blk.data = encoded_tx_data;

    generate
        if (SCRAMBLER_DISABLE != 0) begin : g_scr_bypass
            assign scr_data  = blk.data;
            assign lfsr_step = lfsr_q;
        end else begin : g_scr_on
            lfsr_scrambler_64 u_scr (
                .state_in  (lfsr_q),
                .data_in   (blk.data),
                .data_out  (scr_data),
                .state_out (lfsr_step)
            );
        end
    endgenerate

    // Gearbox: append the new block above the 2*seq_cnt leftover bits, emit the low 64.
    always_comb begin
        pause      = (seq_cnt_q == 6'(GBX_SEQ_MAX));
        cat        = ({62'b0, scr_data, blk.hdr} << {seq_cnt_q, 1'b0}) | {64'b0, leftover_q};
        word       = cat[63:0];
        leftover_d = cat[127:64];
        seq_cnt_d  = seq_cnt_q + 6'd1;
        lfsr_d     = lfsr_step;
        if (pause) begin
            // Leftover is exactly full: flush it and ignore the held input block.
            word       = leftover_q;
            leftover_d = '0;
            seq_cnt_d  = '0;
            lfsr_d     = lfsr_q;
        end
        serdes_d = (BIT_REVERSE != 0) ? bit_reverse64(word) : word;
    end

    // State, leftover and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_cnt_q  <= '0;
            leftover_q <= '0;
            serdes_q   <= '0;
            lfsr_q     <= '1;
        end else begin
            seq_cnt_q  <= seq_cnt_d;
            leftover_q <= leftover_d;
            serdes_q   <= serdes_d;
            lfsr_q     <= lfsr_d;
        end
    end

    assign tx_pause       = (seq_cnt_q == 6'(GBX_SEQ_MAX));
    assign serdes_tx_data = serdes_q;

endmodule
`default_nettype wire

// File: tb/tb_baser_tx_scrambler_gearbox.sv
`default_nettype none
// ============================================================================
//  Module   : tb_baser_tx_scrambler_gearbox
//  Brief    : Directed bench for the scrambler/gearbox with a bit-serial
//             reference, a bypass instance and a bit-reversed instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_baser_tx_scrambler_gearbox;
    import baser_pkg::*;

    logic        clk;
    logic        rst;
    logic [63:0] enc_data;
    logic [1:0]  enc_hdr;
    logic        pause_s, pause_b, pause_r;
    logic [63:0] out_s, out_b, out_r;

    baser_tx_scrambler_gearbox u_dut (
        .clk(clk), .rst(rst), .encoded_tx_data(enc_data), .encoded_tx_hdr(enc_hdr),
        .tx_pause(pause_s), .serdes_tx_data(out_s)
    );

    baser_tx_scrambler_gearbox #(.SCRAMBLER_DISABLE(1)) u_byp (
        .clk(clk), .rst(rst), .encoded_tx_data(enc_data), .encoded_tx_hdr(enc_hdr),
        .tx_pause(pause_b), .serdes_tx_data(out_b)
    );

    baser_tx_scrambler_gearbox #(.BIT_REVERSE(1)) u_rev (
        .clk(clk), .rst(rst), .encoded_tx_data(enc_data), .encoded_tx_hdr(enc_hdr),
        .tx_pause(pause_r), .serdes_tx_data(out_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state
    bit [57:0]   m_lfsr;
    int          m_seq;
    bit          qs[$];
    bit          qb[$];
    logic [63:0] exp_s, exp_b;
    bit          rxq[$];
    bit [57:0]   d_lfsr;
    logic [65:0] sent[$];
    int          ecnt, last_pause;
    bit          first_pause;

    task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rev64(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = v[63-i];
        return r;
    endfunction

    task automatic model_reset();
        m_lfsr = '1;
        m_seq  = 0;
        qs.delete();
        qb.delete();
        exp_s  = '0;
        exp_b  = '0;
        rxq.delete();
        d_lfsr = '1;
        sent.delete();
        ecnt        = 0;
        last_pause  = 0;
        first_pause = 1'b1;
    endtask

    // Bit-serial transmitter model for one rising edge.
    task automatic model_edge(input logic [63:0] d, input logic [1:0] h);
        bit o;
        if (m_seq == 32) begin
            m_seq = 0;
        end else begin
            qs.push_back(h[0]); qs.push_back(h[1]);
            qb.push_back(h[0]); qb.push_back(h[1]);
            for (int i = 0; i < 64; i++) begin
                o      = d[i] ^ m_lfsr[38] ^ m_lfsr[57];
                m_lfsr = {m_lfsr[56:0], o};
                qs.push_back(o);
                qb.push_back(d[i]);
            end
            sent.push_back({d, h});
            m_seq++;
        end
        for (int i = 0; i < 64; i++) begin
            exp_s[i] = qs.pop_front();
            exp_b[i] = qb.pop_front();
        end
    endtask

    // Ungearbox and descramble the DUT stream, comparing against sent blocks.
    task automatic rx_check();
        logic [65:0] blk;
        logic [65:0] ref_blk;
        bit          o;
        for (int i = 0; i < 64; i++) rxq.push_back(out_s[i]);
        while (rxq.size() >= 66) begin
            blk[64] = rxq.pop_front();
            blk[65] = rxq.pop_front();
            for (int i = 0; i < 64; i++) begin
                o      = rxq.pop_front();
                blk[i] = o ^ d_lfsr[38] ^ d_lfsr[57];
                d_lfsr = {d_lfsr[56:0], o};
            end
            ref_blk = (sent.size() > 0) ? sent.pop_front() : 66'h3_FFFF_FFFF_FFFF_FFFF;
            check_eq("rx_block", {blk[63:0], blk[65:64]}, ref_blk);
        end
    endtask

    task automatic cyc(input logic [63:0] d, input logic [1:0] h);
        enc_data = d;
        enc_hdr  = h;
        @(posedge clk);
        model_edge(d, h);
        ecnt++;
        #1;
        check_eq("pause", pause_s, (m_seq == 32));
        check_eq("word_scr", out_s, exp_s);
        check_eq("word_byp", out_b, exp_b);
        check_eq("word_rev", out_r, rev64(exp_s));
        if (pause_s) begin
            if (first_pause) check_eq("first_pause_cycle", ecnt, 32);
            else             check_eq("pause_gap", ecnt - last_pause, 33);
            first_pause = 1'b0;
            last_pause  = ecnt;
        end
        rx_check();
    endtask

    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        check_eq("rst_async_word", out_s, 64'h0);
        check_eq("rst_async_pause", pause_s, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic rand_blk(output logic [63:0] d, output logic [1:0] h);
        d = {$urandom(), $urandom()};
        h = ($urandom_range(0, 1) == 1) ? SYNC_DATA : SYNC_CTRL;
    endtask

    initial begin
        logic [63:0] d;
        logic [1:0]  h;
        rst      = 1'b1;
        enc_data = '0;
        enc_hdr  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_word", out_s, 64'h0);
        check_eq("reset_pause", pause_s, 1'b0);
        rst = 1'b0;

        // Bypass: first word after reset is the header plus shifted payload.
        cyc(64'h0707070707070707, SYNC_CTRL);
        check_eq("byp_first_word", out_b, 64'h1C1C1C1C1C1C1C1E);

        // Continuous random traffic through several pause cycles.
        for (int k = 0; k < 110; k++) begin
            rand_blk(d, h);
            cyc(d, h);
        end

        // Asynchronous reset mid-run, then traffic again.
        do_reset();
        for (int k = 0; k < 45; k++) begin
            rand_blk(d, h);
            cyc(d, h);
        end

        // Poison the inputs only during pause cycles.
        for (int k = 0; k < 80; k++) begin
            rand_blk(d, h);
            if (m_seq == 32) d = 64'hDEADBEEF_CAFEF00D;
            cyc(d, h);
            check_eq("no_dead_in_byp", (out_b == 64'hDEADBEEF_CAFEF00D), 1'b0);
        end

        // Reset with seq_cnt at 17: the next word comes from the new block alone.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            rand_blk(d, h);
            cyc(d, h);
        end
        check_eq("seq_before_rst", m_seq, 17);
        do_reset();
        cyc(64'h0123456789ABCDEF, SYNC_DATA);
        check_eq("byp_after_rst17", out_b, 64'h048D159E26AF37BD);
        for (int k = 0; k < 40; k++) begin
            rand_blk(d, h);
            cyc(d, h);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
